hazard_scoreboard_ctrl: RTL and testbench
=========================================

Name: hazard_scoreboard_ctrl

Overview:
Parametrised hazard controller for the 5-stage RISC-V pipeline. It provides EX-stage forwarding selects, load-use stalls, configurable-depth branch flush, and a single-entry scoreboard for one multi-cycle execution unit (MUL/DIV class) with fixed latency. It also provides saturating stall and flush performance counters. It sits beside the pipeline registers and drives their write-enable and flush inputs, the PC write enable, and the ALU operand muxes.

Parameters:
REG_AW, 5, register address width
BR_STAGE, 3, stage index at which branches resolve (2=EX, 3=MEM); equals number of younger pipeline registers flushed
MC_LAT, 4, multi-cycle unit latency in cycles (>=2)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
id_rd  in  REG_AW  ID destination register
id_regwrite  in  1  ID instruction writes rd
id_is_mc  in  1  ID instruction is a multi-cycle op
ex_rs1, ex_rs2  in  REG_AW  EX-stage sources
ex_rd  in  REG_AW  EX destination register
ex_memread  in  1  EX instruction is a load
mc_issue  in  1  multi-cycle op entering the unit from EX
mc_rd  in  REG_AW  its destination
mem_rd  in  REG_AW  MEM destination register
mem_regwrite  in  1  MEM instruction writes rd
wb_rd  in  REG_AW  WB destination register
wb_regwrite  in  1  WB instruction writes rd
branch_taken  in  1  branch resolved taken at stage BR_STAGE
fwd_a, fwd_b  out  2  ALU operand select: 00 register, 10 EX/MEM result, 01 MEM/WB result
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
flush_vec  out  BR_STAGE  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM flush
mc_busy  out  1  scoreboard entry valid
mc_done  out  1  multi-cycle result valid this cycle
mc_done_rd  out  REG_AW  destination of completing op
stall_cnt  out  CNT_W  cycles stalled, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (rst=0, asynchronous): mc_busy=0, count=0, pending rd=0, stall_cnt=0, flush_cnt=0. Combinational outputs then evaluate with an empty scoreboard.
- Forwarding (combinational): for fwd_a:
  - 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - else 00.
  - MEM has priority over WB. fwd_b is identical using ex_rs2.
- load_use: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- mc_hazard: mc_busy && any of:
  - id_is_mc (structural);
  - a used source == pending rd (RAW);
  - id_regwrite && id_rd == pending rd (WAW).
  - Pending rd==0 never raises RAW or WAW.
- stall = (load_use || mc_hazard) && !branch_taken.
  - On stall: pc_write=0, ifid_write=0, flush_vec[1]=1 (bubble into ID/EX). Otherwise pc_write=ifid_write=1.
- Branch: branch_taken forces flush_vec = all ones for that cycle and pc_write=1. Branch has priority over stall.
- Scoreboard FSM, states IDLE and BUSY:
  - IDLE: on mc_issue && !branch_taken, move to BUSY, count=MC_LAT, latch pending rd=mc_rd.
  - BUSY: count decrements each cycle. At count==1, mc_done=1 and mc_done_rd=pending rd. The next cycle returns to IDLE.
  - An op issued at edge t produces mc_done in the cycle ending at edge t+MC_LAT. mc_busy is 1 from t+1 through the done cycle inclusive.
  - mc_issue while BUSY is a protocol error; the bench asserts it never occurs. The controller ignores it.
  - mc_issue together with branch_taken: the issuing instruction is wrong-path. It is ignored and the FSM stays IDLE.
  - An in-flight op is never cancelled by a branch, because it is older than the branch.
- Counters:
  - stall_cnt increments each cycle with stall=1.
  - flush_cnt increments each cycle with branch_taken=1.
  - Both saturate at 2^CNT_W-1.
- Reset asserted mid-operation abandons the in-flight op immediately. No mc_done follows.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 (mem_rd=5, mem_regwrite=1, ex_rs1=5) -> fwd_a=10. With wb_rd=5 also set -> still 10. Only WB match -> 01. rd=0 match -> 00.
- lw x7 in EX (ex_memread=1, ex_rd=7) with ID id_use_rs2=1, id_rs2=7 -> exactly one cycle of pc_write=0, ifid_write=0, flush_vec[1]=1. stall_cnt goes 0->1.
- mc_issue with mc_rd=9, MC_LAT=4, at edge t -> mc_busy 1 over t+1..t+4, mc_done=1 with mc_done_rd=9 at t+4. An ID instruction reading x9 stalls for 4 cycles and proceeds the cycle after mc_done.
- branch_taken=1 during a load-use condition, BR_STAGE=3 -> flush_vec=111, pc_write=1, stall=0. flush_cnt increments, stall_cnt does not. mc_issue in the same cycle is ignored (mc_busy stays 0).
- CNT_W=4: 20 consecutive stall cycles -> stall_cnt holds at 15.
- rst pulsed low while mc_busy=1 with count=2 -> mc_busy=0 and counters 0 immediately. No mc_done afterwards.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/scoreboard controller.
// The master is the pipeline and the slave is the controller.
interface hazard_scoreboard_ctrl_if #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned CNT_W    = 16
);
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_AW-1:0]   id_rd;
    logic                id_regwrite;
    logic                id_is_mc;
    logic [REG_AW-1:0]   ex_rs1;
    logic [REG_AW-1:0]   ex_rs2;
    logic [REG_AW-1:0]   ex_rd;
    logic                ex_memread;
    logic                mc_issue;
    logic [REG_AW-1:0]   mc_rd;
    logic [REG_AW-1:0]   mem_rd;
    logic                mem_regwrite;
    logic [REG_AW-1:0]   wb_rd;
    logic                wb_regwrite;
    logic                branch_taken;

    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                pc_write;
    logic                ifid_write;
    logic [BR_STAGE-1:0] flush_vec;
    logic                mc_busy;
    logic                mc_done;
    logic [REG_AW-1:0]   mc_done_rd;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_mc,
               ex_rs1, ex_rs2, ex_rd, ex_memread, mc_issue, mc_rd,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
        input  fwd_a, fwd_b, pc_write, ifid_write, flush_vec,
               mc_busy, mc_done, mc_done_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_mc,
               ex_rs1, ex_rs2, ex_rd, ex_memread, mc_issue, mc_rd,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
        output fwd_a, fwd_b, pc_write, ifid_write, flush_vec,
               mc_busy, mc_done, mc_done_rd, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stall,
// branch flush, single-entry multi-cycle scoreboard and perf counters.
module hazard_scoreboard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned MC_LAT   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_scoreboard_ctrl_if.slave hz
);
    localparam int unsigned     LAT_W    = $clog2(MC_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MC_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sb_state_t;

    sb_state_t         state;
    sb_state_t         state_nxt;
    logic [LAT_W-1:0]  count;
    logic [LAT_W-1:0]  count_nxt;
    logic [REG_AW-1:0] pend_rd;
    logic [REG_AW-1:0] pend_rd_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic                busy;
    logic                done;
    logic                load_use;
    logic                raw;
    logic                waw;
    logic                mc_hazard;
    logic                stall;
    logic [BR_STAGE-1:0] flush;

    // MEM/WB result select for one ALU operand; MEM is the younger producer and wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard detection and stall/flush decision
    always_comb begin
        busy     = (state == BUSY);
        done     = busy && (count == LAT_ONE);
        load_use = hz.ex_memread && (hz.ex_rd != '0) &&
                   ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        raw      = (hz.id_use_rs1 && (hz.id_rs1 == pend_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == pend_rd));
        waw      = hz.id_regwrite && (hz.id_rd == pend_rd);
        // x0 as pending destination carries no data dependency
        mc_hazard = busy && (hz.id_is_mc || ((pend_rd != '0) && (raw || waw)));
        stall     = (load_use || mc_hazard) && !hz.branch_taken;

        flush = '0;
        if (hz.branch_taken) begin
            flush = '1;
        end else if (stall) begin
            flush[1] = 1'b1;
        end
    end

    // Scoreboard next state; a branch in the issue cycle marks the issuer wrong-path
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        pend_rd_nxt = pend_rd;
        case (state)
            IDLE: begin
                if (hz.mc_issue && !hz.branch_taken) begin
                    state_nxt   = BUSY;
                    count_nxt   = LAT_INIT;
                    pend_rd_nxt = hz.mc_rd;
                end
            end
            BUSY: begin
                count_nxt = count - LAT_ONE;
                if (count == LAT_ONE) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            pend_rd <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            pend_rd <= pend_rd_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (hz.branch_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.fwd_a      = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    assign hz.fwd_b      = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    assign hz.pc_write   = !stall;
    assign hz.ifid_write = !stall;
    assign hz.flush_vec  = flush;
    assign hz.mc_busy    = busy;
    assign hz.mc_done    = done;
    assign hz.mc_done_rd = done ? pend_rd : '0;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl: vector table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_hazard_scoreboard_ctrl;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned BR_STAGE = 3;
    localparam int unsigned MC_LAT   = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam int          ALL_FLUSH = (1 << BR_STAGE) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(.REG_AW(REG_AW), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard_ctrl #(
        .REG_AW(REG_AW), .BR_STAGE(BR_STAGE), .MC_LAT(MC_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.id_is_mc = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_memread = 1'b0;
        bus.mc_issue = 1'b0; bus.mc_rd = '0;
        bus.mem_rd = '0; bus.mem_regwrite = 1'b0; bus.wb_rd = '0; bus.wb_regwrite = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic set_load_use(input int rd);
        bus.ex_memread = 1'b1; bus.ex_rd = REG_AW'(rd);
        bus.id_use_rs2 = 1'b1; bus.id_rs2 = REG_AW'(rd);
    endtask

    // ---------------- reference model ----------------
    // Scoreboard tracked as the edge index at which the op was accepted;
    // busy/done follow from elapsed edges.
    int cyc   = 0;
    int iss   = -1000;
    int prd   = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic int fsel(input int src, input int mrd, input int mwe, input int wrd, input int wwe);
        if (mwe != 0 && mrd != 0 && mrd == src) return 2;
        if (wwe != 0 && wrd != 0 && wrd == src) return 1;
        return 0;
    endfunction

    function automatic bit m_busy();
        int d = cyc + 1 - iss;
        return (d >= 1) && (d <= int'(MC_LAT));
    endfunction

    function automatic bit m_done();
        return (cyc + 1 - iss) == int'(MC_LAT);
    endfunction

    task automatic model_reset();
        iss = -1000; prd = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_check(output bit st);
        int rs1 = int'(bus.id_rs1), rs2 = int'(bus.id_rs2), exrd = int'(bus.ex_rd);
        bit u1 = bus.id_use_rs1, u2 = bus.id_use_rs2, br = bus.branch_taken;
        bit lu, mh, dep;
        lu  = bus.ex_memread && exrd != 0 && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
        dep = (u1 && rs1 == prd) || (u2 && rs2 == prd) ||
              (bus.id_regwrite && int'(bus.id_rd) == prd);
        mh  = m_busy() && (bus.id_is_mc || (prd != 0 && dep));
        st  = (lu || mh) && !br;
        chk("fwd_a", int'(bus.fwd_a), fsel(int'(bus.ex_rs1), int'(bus.mem_rd), int'(bus.mem_regwrite),
                                           int'(bus.wb_rd), int'(bus.wb_regwrite)));
        chk("fwd_b", int'(bus.fwd_b), fsel(int'(bus.ex_rs2), int'(bus.mem_rd), int'(bus.mem_regwrite),
                                           int'(bus.wb_rd), int'(bus.wb_regwrite)));
        chk("pc_write", int'(bus.pc_write), st ? 0 : 1);
        chk("ifid_write", int'(bus.ifid_write), st ? 0 : 1);
        chk("flush_vec", int'(bus.flush_vec), br ? ALL_FLUSH : (st ? 2 : 0));
        chk("mc_busy", int'(bus.mc_busy), int'(m_busy()));
        chk("mc_done", int'(bus.mc_done), int'(m_done()));
        if (m_done()) chk("mc_done_rd", int'(bus.mc_done_rd), prd);
        chk("stall_cnt", int'(bus.stall_cnt), m_stall);
        chk("flush_cnt", int'(bus.flush_cnt), m_flush);
        chk("issue_while_busy", int'(bus.mc_issue & bus.mc_busy), 0);
    endtask

    task automatic model_edge(input bit st);
        if (st && m_stall < CNT_MAX) m_stall++;
        if (bus.branch_taken && m_flush < CNT_MAX) m_flush++;
        if (!m_busy() && bus.mc_issue && !bus.branch_taken) begin
            iss = cyc + 1;
            prd = int'(bus.mc_rd);
        end
        cyc++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int ex_rs1, ex_rs2, mem_rd, mem_we, wb_rd, wb_we;
        int ld, ex_rd, id_rs1, id_rs2, use1, use2, br;
        int fa, fb, pcw, flush;
    } vec_t;

    vec_t vecs[12];

    task automatic do_reset();
        rst = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
        chk("rst_mc_busy", int'(bus.mc_busy), 0);
        chk("rst_mc_done", int'(bus.mc_done), 0);
        chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
        chk("rst_flush_cnt", int'(bus.flush_cnt), 0);
        chk("rst_pc_write", int'(bus.pc_write), 1);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bit st;

        vecs[0]  = '{5,3,5,1,0,0, 0,0,0,0,0,0,0, 2,0,1,0};
        vecs[1]  = '{5,3,5,1,5,1, 0,0,0,0,0,0,0, 2,0,1,0};
        vecs[2]  = '{5,5,0,0,5,1, 0,0,0,0,0,0,0, 1,1,1,0};
        vecs[3]  = '{0,0,0,1,0,1, 0,0,0,0,0,0,0, 0,0,1,0};
        vecs[4]  = '{3,6,6,1,3,1, 0,0,0,0,0,0,0, 1,2,1,0};
        vecs[5]  = '{5,0,5,0,0,0, 0,0,0,0,0,0,0, 0,0,1,0};
        vecs[6]  = '{0,0,0,0,0,0, 1,7,0,7,0,1,0, 0,0,0,2};
        vecs[7]  = '{0,0,0,0,0,0, 1,7,0,7,0,0,0, 0,0,1,0};
        vecs[8]  = '{0,0,0,1,0,0, 1,0,0,0,1,0,0, 0,0,1,0};
        vecs[9]  = '{0,0,0,0,0,0, 1,7,7,0,1,0,1, 0,0,1,7};
        vecs[10] = '{0,0,0,0,0,0, 0,0,0,0,0,0,1, 0,0,1,7};
        vecs[11] = '{7,0,7,1,0,0, 1,7,7,0,1,0,0, 2,0,0,2};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            clear_in();
            bus.ex_rs1 = REG_AW'(vecs[i].ex_rs1); bus.ex_rs2 = REG_AW'(vecs[i].ex_rs2);
            bus.mem_rd = REG_AW'(vecs[i].mem_rd); bus.mem_regwrite = 1'(vecs[i].mem_we);
            bus.wb_rd  = REG_AW'(vecs[i].wb_rd);  bus.wb_regwrite  = 1'(vecs[i].wb_we);
            bus.ex_memread = 1'(vecs[i].ld);      bus.ex_rd = REG_AW'(vecs[i].ex_rd);
            bus.id_rs1 = REG_AW'(vecs[i].id_rs1); bus.id_rs2 = REG_AW'(vecs[i].id_rs2);
            bus.id_use_rs1 = 1'(vecs[i].use1);    bus.id_use_rs2 = 1'(vecs[i].use2);
            bus.branch_taken = 1'(vecs[i].br);
            #1;
            chk($sformatf("vec%0d_fwd_a", i), int'(bus.fwd_a), vecs[i].fa);
            chk($sformatf("vec%0d_fwd_b", i), int'(bus.fwd_b), vecs[i].fb);
            chk($sformatf("vec%0d_pc_write", i), int'(bus.pc_write), vecs[i].pcw);
            chk($sformatf("vec%0d_ifid_write", i), int'(bus.ifid_write), vecs[i].pcw);
            chk($sformatf("vec%0d_flush_vec", i), int'(bus.flush_vec), vecs[i].flush);
            @(negedge clk);
        end

        // Load-use: exactly one stall cycle
        do_reset();
        set_load_use(7);
        #1;
        chk("lu_pc_write", int'(bus.pc_write), 0);
        chk("lu_ifid_write", int'(bus.ifid_write), 0);
        chk("lu_flush_vec", int'(bus.flush_vec), 2);
        chk("lu_stall_cnt_before", int'(bus.stall_cnt), 0);
        @(negedge clk);
        clear_in();
        #1;
        chk("lu_stall_cnt_after", int'(bus.stall_cnt), 1);
        chk("lu_pc_write_resume", int'(bus.pc_write), 1);

        // Multi-cycle op to x9 with a dependent reader in ID
        bus.mc_issue = 1'b1; bus.mc_rd = REG_AW'(9);
        #1;
        chk("mc_busy_before_issue", int'(bus.mc_busy), 0);
        @(negedge clk);
        clear_in();
        bus.id_use_rs1 = 1'b1; bus.id_rs1 = REG_AW'(9);
        for (int k = 1; k <= int'(MC_LAT); k++) begin
            #1;
            chk($sformatf("mc_busy_c%0d", k), int'(bus.mc_busy), 1);
            chk($sformatf("mc_raw_stall_c%0d", k), int'(bus.pc_write), 0);
            chk($sformatf("mc_done_c%0d", k), int'(bus.mc_done), (k == int'(MC_LAT)) ? 1 : 0);
            if (k == int'(MC_LAT)) chk("mc_done_rd", int'(bus.mc_done_rd), 9);
            @(negedge clk);
        end
        #1;
        chk("mc_busy_after", int'(bus.mc_busy), 0);
        chk("mc_reader_proceeds", int'(bus.pc_write), 1);
        chk("mc_stall_cnt", int'(bus.stall_cnt), 1 + int'(MC_LAT));

        // Branch overrides load-use and kills a same-cycle issue
        @(negedge clk);
        clear_in();
        set_load_use(7);
        bus.branch_taken = 1'b1; bus.mc_issue = 1'b1; bus.mc_rd = REG_AW'(3);
        #1;
        chk("br_flush_vec", int'(bus.flush_vec), ALL_FLUSH);
        chk("br_pc_write", int'(bus.pc_write), 1);
        chk("br_ifid_write", int'(bus.ifid_write), 1);
        @(negedge clk);
        clear_in();
        #1;
        chk("br_mc_ignored", int'(bus.mc_busy), 0);
        chk("br_flush_cnt", int'(bus.flush_cnt), 1);
        chk("br_stall_cnt_held", int'(bus.stall_cnt), 1 + int'(MC_LAT));

        // Stall counter saturation
        set_load_use(4);
        repeat (20) @(negedge clk);
        clear_in();
        #1;
        chk("stall_cnt_sat", int'(bus.stall_cnt), CNT_MAX);

        // Reset in the middle of an in-flight op
        @(negedge clk);
        bus.mc_issue = 1'b1; bus.mc_rd = REG_AW'(4);
        @(negedge clk);
        clear_in();
        repeat (2) @(negedge clk);
        chk("midop_busy", int'(bus.mc_busy), 1);
        rst = 1'b0;
        #1;
        chk("midop_rst_busy", int'(bus.mc_busy), 0);
        chk("midop_rst_stall_cnt", int'(bus.stall_cnt), 0);
        chk("midop_rst_flush_cnt", int'(bus.flush_cnt), 0);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midop_no_done_%0d", k), int'(bus.mc_done), 0);
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                chk("rand_rst_busy", int'(bus.mc_busy), 0);
                chk("rand_rst_stall_cnt", int'(bus.stall_cnt), 0);
                model_reset();
                rst = 1'b1;
            end
            bus.id_rs1 = REG_AW'($urandom_range(0, 7));
            bus.id_rs2 = REG_AW'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom_range(0, 1));
            bus.id_use_rs2 = 1'($urandom_range(0, 1));
            bus.id_rd = REG_AW'($urandom_range(0, 7));
            bus.id_regwrite = 1'($urandom_range(0, 1));
            bus.id_is_mc = ($urandom_range(0, 5) == 0);
            bus.ex_rs1 = REG_AW'($urandom_range(0, 7));
            bus.ex_rs2 = REG_AW'($urandom_range(0, 7));
            bus.ex_rd = REG_AW'($urandom_range(0, 7));
            bus.ex_memread = ($urandom_range(0, 2) == 0);
            bus.mem_rd = REG_AW'($urandom_range(0, 7));
            bus.mem_regwrite = 1'($urandom_range(0, 1));
            bus.wb_rd = REG_AW'($urandom_range(0, 7));
            bus.wb_regwrite = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            bus.mc_rd = REG_AW'($urandom_range(0, 7));
            bus.mc_issue = !m_busy() && ($urandom_range(0, 3) == 0);
            #1;
            model_check(st);
            @(posedge clk);
            model_edge(st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
